// File: rtl/deep_buffered_pipeline_if.sv
// rtl/deep_buffered_pipeline_if.sv - handshake and status bundle for deep_buffered_pipeline
interface deep_buffered_pipeline_if #(
    parameter int DATA_END   = 0,
    parameter int COUNT_BITS = 4
);
    logic                  validIn;
    logic [DATA_END:0]     dataIn;
    logic                  busyIn;
    logic                  validOut;
    logic                  flush;
    logic                  busyOut;
    logic [DATA_END:0]     currentData;
    logic                  validData;
    logic                  memoryTransfer;
    logic [COUNT_BITS-1:0] occupancy;
    logic                  overflow;

    modport master (
        output validIn, dataIn, busyIn, validOut, flush,
        input  busyOut, currentData, validData, memoryTransfer, occupancy, overflow
    );

    modport slave (
        input  validIn, dataIn, busyIn, validOut, flush,
        output busyOut, currentData, validData, memoryTransfer, occupancy, overflow
    );
endinterface

// File: rtl/deep_buffered_pipeline.sv
// rtl/deep_buffered_pipeline.sv - head register plus in-order store for a stalling pipeline stage
module deep_buffered_pipeline #(
    parameter int DATA_END    = 0,
    parameter int STORE_DEPTH = 4,
    parameter int BUSY_SLACK  = 0,
    parameter int COUNT_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    deep_buffered_pipeline_if.slave pipe
);
    localparam int PTR_BITS = (STORE_DEPTH > 1) ? $clog2(STORE_DEPTH) : 1;
    localparam logic [PTR_BITS-1:0]   LAST_PTR = PTR_BITS'(STORE_DEPTH - 1);
    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(STORE_DEPTH);
    // busyOut when free entries <= BUSY_SLACK, i.e. count >= STORE_DEPTH - BUSY_SLACK
    localparam logic [COUNT_BITS-1:0] BUSY_COUNT = COUNT_BITS'(STORE_DEPTH - BUSY_SLACK);

    logic [DATA_END:0]     headData;
    logic                  headValid;
    logic                  overflowFlag;
    logic [DATA_END:0]     store [STORE_DEPTH];
    logic [PTR_BITS-1:0]   rdPtr;
    logic [PTR_BITS-1:0]   wrPtr;
    logic [COUNT_BITS-1:0] count;

    logic storeFull;
    logic storeEmpty;
    logic transfer;
    logic accept;
    logic pushEn;
    logic popEn;

    function automatic logic [PTR_BITS-1:0] nextPtr(input logic [PTR_BITS-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode; a push during a pop is always legal because the pop frees the slot
    always_comb begin
        storeFull  = (count == FULL_COUNT);
        storeEmpty = (count == '0);
        transfer   = pipe.validOut & ~pipe.busyIn;
        accept     = pipe.validIn & (~headValid | transfer | ~storeFull);
        popEn      = ~pipe.flush & headValid & transfer & ~storeEmpty;
        pushEn     = ~pipe.flush & headValid & pipe.validIn &
                     (transfer ? ~storeEmpty : ~storeFull);
    end

    // Store contents: written at the write pointer on every push
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STORE_DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (pushEn) begin
            store[wrPtr] <= pipe.dataIn;
        end
    end

    // Head register, store pointers/count and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            headData     <= '0;
            headValid    <= 1'b0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            overflowFlag <= 1'b0;
        end else if (pipe.flush) begin
            headData  <= '0;
            headValid <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
        end else begin
            if (pipe.validIn && !accept) begin
                overflowFlag <= 1'b1;
            end
            if (pushEn) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (popEn) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (pushEn && !popEn) begin
                count <= count + 1'b1;
            end else if (popEn && !pushEn) begin
                count <= count - 1'b1;
            end

            if (!headValid) begin
                if (pipe.validIn) begin
                    headData  <= pipe.dataIn;
                    headValid <= 1'b1;
                end
            end else if (transfer) begin
                if (!storeEmpty) begin
                    headData <= store[rdPtr];
                end else if (pipe.validIn) begin
                    headData <= pipe.dataIn;
                end else begin
                    headData  <= '0;
                    headValid <= 1'b0;
                end
            end
        end
    end

    // Outside logic must not claim a result for an empty head
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pipe.validOut && !headValid))
                else $fatal(1, "%m: validOut asserted while validData is low");
        end
    end

    assign pipe.currentData    = headData;
    assign pipe.validData      = headValid;
    assign pipe.memoryTransfer = transfer;
    assign pipe.busyOut        = (count >= BUSY_COUNT);
    assign pipe.occupancy      = count + COUNT_BITS'(headValid);
    assign pipe.overflow       = overflowFlag;
endmodule

// File: doc/deep_buffered_pipeline.md
# deep_buffered_pipeline

Parametrised successor to the single-slot buffered pipeline stage control unit. It registers incoming data into a head register that feeds the stage's outside logic. It absorbs upstream data while the downstream stage stalls in an in-order store of `STORE_DEPTH` entries, with early-warning busy, flush and overflow detection. It sits between any two stages of the BDD pipeline and lets upstream stages with registered busy paths run without losing data.

## Interface
- `DATA_END`, 0: MSB index of the data bus; data width is `DATA_END+1`.
- `STORE_DEPTH`, 4: number of store entries behind the head register; must be ≥1.
- `BUSY_SLACK`, 0: `busyOut` asserts when free store entries ≤ `BUSY_SLACK`; must be < `STORE_DEPTH`.
- `COUNT_BITS`, 4: width of `occupancy`; must satisfy 2^`COUNT_BITS` > `STORE_DEPTH`+1.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `validIn`  in  1  previous stage presents valid `dataIn`.
- `dataIn`  in  `DATA_END+1`  data from previous stage.
- `busyIn`  in  1  next stage cannot accept.
- `validOut`  in  1  outside logic has produced a result for `currentData`; legal only while `validData`=1.
- `flush`  in  1  discards the head and all stored entries at the next edge.
- `busyOut`  out  1  tells the previous stage to stop sending.
- `currentData`  out  `DATA_END+1`  head register contents.
- `validData`  out  1  head register holds valid data.
- `memoryTransfer`  out  1  = `validOut & !busyIn`; head leaves this cycle.
- `occupancy`  out  `COUNT_BITS`  `validData` + store count (0..`STORE_DEPTH`+1).
- `overflow`  out  1  sticky; set when valid input was dropped.

## Operation
- State:
  - Head register plus `validData` flag.
  - Circular store: read pointer, write pointer and `count` (0..`STORE_DEPTH`). Pointers wrap from `STORE_DEPTH-1` to 0.
- `accept = validIn & (!validData | memoryTransfer | count < STORE_DEPTH)`.
- `validIn` while `accept`=0: data is dropped and `overflow` is set. `overflow` clears only on reset.
- The store only ever holds data while `validData`=1. Order out of the block equals order in.
- Per-edge behaviour, in priority order:
  1. `reset`: head, store and flags cleared; `currentData`=0.
  2. `flush`: `validData`=0, `count`=0, pointers=0, `currentData`=0. Input in the same cycle is discarded (not an overflow).
  3. Head empty: if `validIn`, head loads `dataIn` and `validData`=1.
  4. `memoryTransfer` with `count`>0: head loads store front and the store is popped. If `validIn`, `dataIn` is pushed in the same edge; the count is unchanged, and this push is legal even when full.
  5. `memoryTransfer` with `count`=0: if `validIn`, head loads `dataIn`. Otherwise `validData`=0 and `currentData`=0.
  6. Head held (no transfer): if `validIn` and `count < STORE_DEPTH`, `dataIn` is pushed.
- `busyOut = (STORE_DEPTH - count) <= BUSY_SLACK`. It is decoded from registers only, with no combinational path from any input.
- Simulation check: `validOut`=1 while `validData`=0 prints the instance path and stops the simulation.

## Timing
- Reset values: `validData`=0, `currentData`=0, `busyOut`=0, `occupancy`=0, `overflow`=0. `memoryTransfer` follows its inputs.
- Latency into an empty stage: data on `dataIn` at edge N is on `currentData` with `validData`=1 after edge N.
- `memoryTransfer` is combinational in the same cycle as `validOut`. The head is replaced at that cycle's closing edge, so back-to-back transfers sustain 1 item/cycle.
- `busyOut`/`occupancy` update one edge after the push/pop that changes `count`.
- With `BUSY_SLACK`=k, an upstream whose busy reaction lags by up to k cycles never overflows.
- Reset or flush in mid-stall leaves no residue: the first item after either appears as in the empty-stage case.

## Test plan
- `DATA_END`=7, `STORE_DEPTH`=4, `BUSY_SLACK`=0, `busyIn`=0, `validOut`=`validData`, stream 0x01..0x10 -> outputs 0x01..0x10 in order, one per cycle after 1-cycle latency; `occupancy`≤1; `busyOut` never asserts.
- Same config, `busyIn`=1, send 0x11..0x15 on consecutive cycles -> `occupancy`=5 and `busyOut`=1 after the fifth edge; a sixth item 0x16 sets `overflow`=1. Release `busyIn` -> 0x11..0x15 drain in order.
- `BUSY_SLACK`=2, `busyIn`=1, upstream keeps sending for 2 cycles after `busyOut` -> `busyOut` asserts at `count`=2, the 2 late items are stored, `occupancy`=5, `overflow`=0.
- Store full (`count`=4, head 0x20), `validOut`=1, `busyIn`=0, `validIn` with 0x30 in the same cycle -> head becomes the store front, 0x30 is stored, `count` stays 4, `overflow`=0.
- `occupancy`=3, assert `flush` with `validIn`=1 (0x44) -> next cycle `validData`=0, `occupancy`=0, `busyOut`=0, `overflow` unchanged; 0x55 sent next appears on `currentData` one cycle later.
- Assert `reset` for 1 cycle mid-stall with `occupancy`=4 and `overflow`=1 -> all outputs return to reset values; normal streaming then resumes.
